trigger_scheduler: RTL
======================

Name: trigger_scheduler

Overview:
Sits on ep_clk behind a Trigger In endpoint. Captures one-cycle trigger pulses from its 32-bit ep_trigger vector into a pending register and arbitrates among pending bits (round-robin or fixed priority). Issues one trigger at a time to downstream consumers over a valid/ready handshake, with a programmable hold-off between grants. Reports pending state, sticky overflow (lost) triggers and a serviced count.

Parameters:
RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
HOLDOFF, 0, idle cycles after each completed handshake before the next grant (0..255).
CNT_W, 16, width of serv_count.

Ports:
ep_clk  in  1  clock.
ti_reset  in  1  asynchronous, active-high reset.
ep_trigger  in  32  one-cycle trigger pulses from the endpoint; bit i high = one event on channel i.
trig_mask  in  32  capture enable per channel; 1 = capture.
serv_ready  in  1  consumer accepts the current serv_id.
ovf_clr  in  1  single-cycle clear of overflow.
serv_valid  out  1  serv_id is a valid request.
serv_id  out  5  channel being serviced.
pending  out  32  captured, unserviced triggers.
overflow  out  32  sticky: a trigger arrived while its channel was already pending.
serv_count  out  CNT_W  completed handshakes, wraps modulo 2^CNT_W.
busy  out  1  state != IDLE.

Behaviour:
- Reset (ti_reset=1, async): pending=0, overflow=0, serv_valid=0, serv_id=0, serv_count=0, busy=0, state=IDLE, last_id=31 (so RR starts at bit 0), hold-off counter=0. Reset mid-handshake drops the request with no completion counted.
- Capture per edge, per bit i: cap_i = ep_trigger[i] & trig_mask[i]; clr_i = handshake completes this edge on id i.
  pending[i]_next = cap_i | (pending[i] & ~clr_i).
  overflow[i] sets when cap_i & pending[i] & ~clr_i. A pulse coinciding with the clearing handshake re-arms pending and is not an overflow.
- Clearing trig_mask does not clear existing pending bits.
- ovf_clr clears overflow. A same-cycle overflow set wins over ovf_clr.
- States:
  IDLE: if pending != 0, select winner; serv_id <= winner; serv_valid <= 1; go to GRANT. Selection uses the registered pending, so a pulse sampled at edge k gives pending=1 after edge k and serv_valid=1 after edge k+1 (2-cycle latency).
  GRANT: serv_valid and serv_id are held stable until serv_ready=1. On valid&ready: clear pending[serv_id], last_id <= serv_id, serv_count += 1, serv_valid <= 0. Then go to HOLD with counter=HOLDOFF-1 if HOLDOFF>0, else IDLE.
  HOLD: counter decrements each cycle; go to IDLE when it reaches 0. Triggers are still captured during HOLD.
- RR select: first set bit scanning upward from last_id+1 modulo 32. Fixed select: lowest set bit.
- Back-to-back rate with HOLDOFF=0: one grant per 2 cycles (IDLE, GRANT with ready=1).
- serv_ready outside GRANT is ignored.
- Exactly one serv_valid cycle sequence per grant. serv_count wraps 2^CNT_W-1 -> 0.

Test Plan:
- Reset, then pulse ep_trigger=0x0000_0004 with mask=all-ones and ready=1 -> serv_valid rises 2 cycles later with serv_id=2. pending clears after handshake; serv_count=1.
- RR_MODE=1: pulse 0x8000_0003 in one cycle, ready=1 -> grants in order ids 0, 1, 31. Repeat with last_id=0 and pending 0x3 -> next grant is id 1.
- Hold ready=0 for 10 cycles while serv_valid=1 with serv_id=5 -> serv_id stays stable. A second pulse on bit 5 sets overflow=0x20. Then ovf_clr=1 -> overflow=0.
- Pulse bit 3 in the exact cycle its handshake completes -> pending[3]=1 afterward, overflow[3]=0, and id 3 is granted again.
- HOLDOFF=4 with two pending bits, ready=1 -> second serv_valid rises exactly 4 cycles later than with HOLDOFF=0.
- Assert ti_reset during GRANT -> serv_valid, pending and busy drop to 0 immediately (async); serv_count=0. mask=0x0 with pulse 0xFFFF_FFFF -> pending stays 0.

Source files
------------

// File: rtl/trigger_scheduler.sv
// rtl/trigger_scheduler.sv - captures trigger pulses into a pending vector and
// issues them one at a time over a valid/ready handshake with optional hold-off.
module trigger_scheduler #(
  parameter int RR_MODE = 1,
  parameter int HOLDOFF = 0,
  parameter int CNT_W   = 16
) (
  input  logic             ep_clk,
  input  logic             ti_reset,
  input  logic [31:0]      ep_trigger,
  input  logic [31:0]      trig_mask,
  input  logic             serv_ready,
  input  logic             ovf_clr,
  output logic             serv_valid,
  output logic [4:0]       serv_id,
  output logic [31:0]      pending,
  output logic [31:0]      overflow,
  output logic [CNT_W-1:0] serv_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam bit         HAS_HOLD  = (HOLDOFF > 0);
  localparam logic [7:0] HOLD_INIT = HAS_HOLD ? 8'(HOLDOFF - 1) : 8'd0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pending;
  logic [31:0]      r_overflow;
  logic             r_valid;
  logic [4:0]       r_id;
  logic [4:0]       r_last_id;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_hold_cnt;

  logic             w_grant;
  logic             w_done;
  logic [31:0]      w_cap;
  logic [31:0]      w_clr;
  logic [31:0]      w_pending_nxt;
  logic [31:0]      w_ovf_set;
  logic [4:0]       w_idx;
  logic [4:0]       w_rr_id;
  logic [4:0]       w_fp_id;
  logic [4:0]       w_winner;

  // A pulse landing on the edge that clears its own bit re-arms it without
  // being counted as lost.
  assign w_cap         = ep_trigger & trig_mask;
  assign w_clr         = w_done ? (32'd1 << r_id) : 32'd0;
  assign w_pending_nxt = w_cap | (r_pending & ~w_clr);
  assign w_ovf_set     = w_cap & r_pending & ~w_clr;

  // Descending scan so the lowest offset (first match) is the final assignment.
  always_comb begin
    w_rr_id = 5'd0;
    w_fp_id = 5'd0;
    w_idx   = 5'd0;
    for (int k = 31; k >= 0; k--) begin
      if (r_pending[5'(k)]) w_fp_id = 5'(k);
      w_idx = r_last_id + 5'd1 + 5'(k);
      if (r_pending[w_idx]) w_rr_id = w_idx;
    end
  end

  assign w_winner = (RR_MODE != 0) ? w_rr_id : w_fp_id;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_grant     = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (r_valid && serv_ready) begin
          w_done      = 1'b1;
          w_state_nxt = HAS_HOLD ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == 8'd0) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ep_clk or posedge ti_reset) begin
    if (ti_reset) begin
      r_state    <= S_IDLE;
      r_pending  <= 32'd0;
      r_overflow <= 32'd0;
      r_valid    <= 1'b0;
      r_id       <= 5'd0;
      r_last_id  <= 5'd31;
      r_count    <= '0;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_overflow <= (ovf_clr ? 32'd0 : r_overflow) | w_ovf_set;
      if (w_grant) begin
        r_valid <= 1'b1;
        r_id    <= w_winner;
      end
      if (w_done) begin
        r_valid    <= 1'b0;
        r_count    <= r_count + CNT_W'(1);
        r_last_id  <= r_id;
        r_hold_cnt <= HOLD_INIT;
      end else if (r_state == S_HOLD && r_hold_cnt != 8'd0) begin
        r_hold_cnt <= r_hold_cnt - 8'd1;
      end
    end
  end

  assign serv_valid = r_valid;
  assign serv_id    = r_id;
  assign pending    = r_pending;
  assign overflow   = r_overflow;
  assign serv_count = r_count;
  assign busy       = (r_state != S_IDLE);

endmodule
